// File: rtl/alu_arbiter_if.sv
// Request/response and ALU-facing signal bundle for alu_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the shared ALU.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid_a;
  logic                  req_valid_b;
  logic                  req_ready_a;
  logic                  req_ready_b;
  logic [DATA_WIDTH-1:0] req_op1_a;
  logic [DATA_WIDTH-1:0] req_op2_a;
  logic [DATA_WIDTH-1:0] req_op1_b;
  logic [DATA_WIDTH-1:0] req_op2_b;
  logic [3:0]            req_code_a;
  logic [3:0]            req_code_b;

  logic                  rsp_valid_a;
  logic                  rsp_valid_b;
  logic                  rsp_ready_a;
  logic                  rsp_ready_b;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic                  rsp_v;
  logic                  rsp_n;
  logic                  rsp_z;
  logic                  rsp_err;

  logic [DATA_WIDTH-1:0] alu_op1;
  logic [DATA_WIDTH-1:0] alu_op2;
  logic [3:0]            alu_control_code;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_v_flag;
  logic                  alu_n_flag;
  logic                  alu_z_flag;

  modport slave (
    input  req_valid_a, req_valid_b, req_op1_a, req_op2_a, req_op1_b, req_op2_b,
           req_code_a, req_code_b, rsp_ready_a, rsp_ready_b,
           alu_result, alu_v_flag, alu_n_flag, alu_z_flag,
    output req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b,
           rsp_result, rsp_v, rsp_n, rsp_z, rsp_err,
           alu_op1, alu_op2, alu_control_code
  );

  modport master (
    output req_valid_a, req_valid_b, req_op1_a, req_op2_a, req_op1_b, req_op2_b,
           req_code_a, req_code_b, rsp_ready_a, rsp_ready_b,
           alu_result, alu_v_flag, alu_n_flag, alu_z_flag,
    input  req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b,
           rsp_result, rsp_v, rsp_n, rsp_z, rsp_err,
           alu_op1, alu_op2, alu_control_code
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external 32-bit ALU between requesters A and B.
// Each op takes IDLE -> EXEC -> RESP; unsupported codes skip EXEC and answer with an error.
module alu_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  typedef enum logic {SIDE_A, SIDE_B} side_t;

  localparam logic [3:0] CODE_ADD = 4'b0010;
  localparam logic [3:0] CODE_SUB = 4'b0110;
  localparam logic [3:0] CODE_NOP = 4'b1111;

  function automatic logic code_supported(input logic [3:0] code);
    case (code)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
      4'b1001, 4'b1100, 4'b1101, 4'b1111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  state_t                state, next_state;
  side_t                 prio, owner;
  logic                  ready_a, ready_b, valid_a, valid_b;
  logic                  accept, rsp_done;
  logic [DATA_WIDTH-1:0] sel_op1, sel_op2;
  logic [3:0]            sel_code;
  logic [DATA_WIDTH-1:0] alu_op1_q, alu_op2_q, result_q;
  logic [3:0]            alu_code_q;
  logic                  v_q, n_q, z_q, err_q;

  // At most one ready is ever high, so ready_b alone picks the winning side.
  assign sel_op1  = ready_b ? bus.req_op1_b  : bus.req_op1_a;
  assign sel_op2  = ready_b ? bus.req_op2_b  : bus.req_op2_a;
  assign sel_code = ready_b ? bus.req_code_b : bus.req_code_a;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    next_state = state;
    ready_a    = 1'b0;
    ready_b    = 1'b0;
    valid_a    = 1'b0;
    valid_b    = 1'b0;
    accept     = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        ready_a = bus.req_valid_a && (prio == SIDE_A || !bus.req_valid_b);
        ready_b = bus.req_valid_b && (prio == SIDE_B || !bus.req_valid_a);
        accept  = ready_a || ready_b;
        if (accept) next_state = code_supported(sel_code) ? EXEC : RESP;
      end
      EXEC: next_state = RESP;
      RESP: begin
        valid_a  = (owner == SIDE_A);
        valid_b  = (owner == SIDE_B);
        rsp_done = (valid_a && bus.rsp_ready_a) || (valid_b && bus.rsp_ready_b);
        if (rsp_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio       <= SIDE_A;
      owner      <= SIDE_A;
      alu_op1_q  <= '0;
      alu_op2_q  <= '0;
      alu_code_q <= CODE_NOP;
      result_q   <= '0;
      v_q        <= 1'b0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        owner <= ready_b ? SIDE_B : SIDE_A;
        // Rejected codes never reach the ALU registers, so the ALU cannot see them.
        if (code_supported(sel_code)) begin
          alu_op1_q  <= sel_op1;
          alu_op2_q  <= sel_op2;
          alu_code_q <= sel_code;
        end else begin
          result_q <= '0;
          v_q      <= 1'b0;
          n_q      <= 1'b0;
          z_q      <= 1'b0;
          err_q    <= 1'b1;
        end
      end

      if (state == EXEC) begin
        err_q <= 1'b0;
        if (alu_code_q != CODE_NOP) begin
          result_q <= bus.alu_result;
          z_q      <= bus.alu_z_flag;
          if (alu_code_q == CODE_ADD || alu_code_q == CODE_SUB) begin
            v_q <= bus.alu_v_flag;
            n_q <= bus.alu_n_flag;
          end else begin
            v_q <= 1'b0;
            n_q <= 1'b0;
          end
        end
      end

      if (rsp_done) prio <= (owner == SIDE_A) ? SIDE_B : SIDE_A;
    end
  end

  assign bus.req_ready_a      = ready_a;
  assign bus.req_ready_b      = ready_b;
  assign bus.rsp_valid_a      = valid_a;
  assign bus.rsp_valid_b      = valid_b;
  assign bus.rsp_result       = result_q;
  assign bus.rsp_v            = v_q;
  assign bus.rsp_n            = n_q;
  assign bus.rsp_z            = z_q;
  assign bus.rsp_err          = err_q;
  assign bus.alu_op1          = alu_op1_q;
  assign bus.alu_op2          = alu_op2_q;
  assign bus.alu_control_code = alu_code_q;

endmodule
